// File: rtl/proc16_pkg.sv
// Shared instruction-format constants for the 16-bit processor datapath and control unit.
// The field offsets describe the default format; parameterised users derive their own.
package proc16_pkg;

    localparam int unsigned PROC_IW  = 16;
    localparam int unsigned PROC_OPW = 4;
    localparam int unsigned PROC_RW  = 4;

    // Most-significant bit of each field in the default instruction format
    localparam int unsigned OPCODE_MSB   = PROC_IW - 1;
    localparam int unsigned RT_BT_MSB    = 3 * PROC_RW - 1;
    localparam int unsigned SWLW_MSB     = 3 * PROC_RW - 1;
    localparam int unsigned OFFSET_MSB   = 2 * PROC_RW + PROC_RW / 2 - 1;
    localparam int unsigned READ1_MSB    = 2 * PROC_RW - 1;
    localparam int unsigned READ2_MSB    = PROC_RW - 1;
    localparam int unsigned FUNCFIELD_MSB = PROC_RW - 1;

    // Field widths in the default instruction format
    localparam int unsigned OPCODE_W = PROC_OPW;
    localparam int unsigned REG_W    = PROC_RW;
    localparam int unsigned HALF_W   = PROC_RW / 2;

endpackage

// File: rtl/ir_fifo.sv
// Circular prefetch queue. A pop in the same cycle frees a slot, so a push to a full
// queue is accepted when it coincides with a pop; flush overrides both.
module ir_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem[rd_ptr_q];

    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/instr_prefetch_ir.sv
// Instruction register fed by a small prefetch queue; decoded fields are slices of the
// registered instruction so no input reaches an output combinationally.
module instr_prefetch_ir
    import proc16_pkg::*;
#(
    parameter int unsigned IW    = PROC_IW,
    parameter int unsigned OPW   = PROC_OPW,
    parameter int unsigned RW    = PROC_RW,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [IW-1:0]          D_MemData,
    input  logic                   C_IRWrite,
    input  logic                   C_IRAdvance,
    input  logic                   C_Flush,
    output logic [OPW-1:0]         OPCODE,
    output logic [RW-1:0]          A_WriteRegRT_BT,
    output logic [RW/2-1:0]        A_RegSWLW,
    output logic [RW/2-1:0]        A_Offset,
    output logic [RW-1:0]          A_ReadReg1RT,
    output logic [RW-1:0]          A_ReadReg2RT,
    output logic [RW-1:0]          FUNCFIELD,
    output logic                   IR_Valid,
    output logic                   Q_Full,
    output logic                   Q_Empty,
    output logic [$clog2(DEPTH):0] Q_Count,
    output logic                   Q_Overflow
);

    logic [IW-1:0] ir_q;
    logic          ir_valid_q;
    logic          overflow_q;

    logic [IW-1:0] fifo_head;
    logic          fifo_full, fifo_empty;
    logic          fifo_push, fifo_pop;
    logic          bypass, drop;

    // An advance into an empty queue takes the incoming word directly, leaving the queue empty
    assign bypass    = C_IRAdvance && !C_Flush && fifo_empty && C_IRWrite;
    assign fifo_pop  = C_IRAdvance && !C_Flush && !fifo_empty;
    assign fifo_push = C_IRWrite && !C_Flush && !bypass;
    assign drop      = C_IRWrite && !C_Flush && fifo_full && !C_IRAdvance;

    ir_fifo #(
        .WIDTH (IW),
        .DEPTH (DEPTH)
    ) u_ir_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (C_Flush),
        .wdata (D_MemData),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (Q_Count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            overflow_q <= 1'b0;
        end else if (C_Flush) begin
            ir_valid_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (C_IRAdvance) begin
                if (!fifo_empty) begin
                    ir_q       <= fifo_head;
                    ir_valid_q <= 1'b1;
                end else if (C_IRWrite) begin
                    ir_q       <= D_MemData;
                    ir_valid_q <= 1'b1;
                end else begin
                    ir_valid_q <= 1'b0;
                end
            end
            if (drop) overflow_q <= 1'b1;
        end
    end

    assign OPCODE          = ir_q[IW-1 -: OPW];
    assign A_WriteRegRT_BT = ir_q[3*RW-1 -: RW];
    assign A_RegSWLW       = ir_q[3*RW-1 -: RW/2];
    assign A_Offset        = ir_q[2*RW+RW/2-1 -: RW/2];
    assign A_ReadReg1RT    = ir_q[2*RW-1 -: RW];
    assign A_ReadReg2RT    = ir_q[RW-1:0];
    assign FUNCFIELD       = ir_q[RW-1:0];

    assign IR_Valid   = ir_valid_q;
    assign Q_Overflow = overflow_q;
    assign Q_Full     = fifo_full;
    assign Q_Empty    = fifo_empty;

endmodule

// File: tb/tb_instr_prefetch_ir.sv
// Scoreboard bench: stimulus updates a queue-based model and enqueues expected state;
// a monitor compares the DUT one step after each clock edge.
module tb_instr_prefetch_ir;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] D_MemData;
    logic        C_IRWrite, C_IRAdvance, C_Flush;
    logic [3:0]  OPCODE, A_WriteRegRT_BT, A_ReadReg1RT, A_ReadReg2RT, FUNCFIELD;
    logic [1:0]  A_RegSWLW, A_Offset;
    logic        IR_Valid, Q_Full, Q_Empty, Q_Overflow;
    logic [2:0]  Q_Count;

    instr_prefetch_ir dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .D_MemData       (D_MemData),
        .C_IRWrite       (C_IRWrite),
        .C_IRAdvance     (C_IRAdvance),
        .C_Flush         (C_Flush),
        .OPCODE          (OPCODE),
        .A_WriteRegRT_BT (A_WriteRegRT_BT),
        .A_RegSWLW       (A_RegSWLW),
        .A_Offset        (A_Offset),
        .A_ReadReg1RT    (A_ReadReg1RT),
        .A_ReadReg2RT    (A_ReadReg2RT),
        .FUNCFIELD       (FUNCFIELD),
        .IR_Valid        (IR_Valid),
        .Q_Full          (Q_Full),
        .Q_Empty         (Q_Empty),
        .Q_Count         (Q_Count),
        .Q_Overflow      (Q_Overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] ir;
        logic        valid;
        int          count;
        logic        ovf;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] mq[$];
    logic [15:0] m_ir;
    logic        m_valid, m_ovf;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic compare_outputs(input exp_t e);
        chk("OPCODE",          32'(OPCODE),          32'((e.ir >> 12) & 16'hF));
        chk("A_WriteRegRT_BT", 32'(A_WriteRegRT_BT), 32'((e.ir >> 8) & 16'hF));
        chk("A_RegSWLW",       32'(A_RegSWLW),       32'((e.ir >> 10) & 16'h3));
        chk("A_Offset",        32'(A_Offset),        32'((e.ir >> 8) & 16'h3));
        chk("A_ReadReg1RT",    32'(A_ReadReg1RT),    32'((e.ir >> 4) & 16'hF));
        chk("A_ReadReg2RT",    32'(A_ReadReg2RT),    32'(e.ir & 16'hF));
        chk("FUNCFIELD",       32'(FUNCFIELD),       32'(e.ir & 16'hF));
        chk("IR_Valid",        32'(IR_Valid),        32'(e.valid));
        chk("Q_Count",         32'(Q_Count),         32'(e.count));
        chk("Q_Full",          32'(Q_Full),          32'(e.count == DEPTH));
        chk("Q_Empty",         32'(Q_Empty),         32'(e.count == 0));
        chk("Q_Overflow",      32'(Q_Overflow),      32'(e.ovf));
    endtask

    function automatic exp_t snapshot();
        exp_t e;
        e.ir    = m_ir;
        e.valid = m_valid;
        e.count = mq.size();
        e.ovf   = m_ovf;
        return e;
    endfunction

    // Behavioural model: flush wins; an advance takes the oldest queued word, or the
    // incoming word when nothing is queued; any word not consumed joins the queue if room.
    task automatic model_step(input logic wr, input logic adv, input logic fl,
                              input logic [15:0] data);
        logic consumed;
        consumed = 1'b0;
        if (fl) begin
            mq.delete();
            m_valid = 1'b0;
            m_ovf   = 1'b0;
        end else begin
            if (adv) begin
                if (mq.size() > 0) begin
                    m_ir    = mq.pop_front();
                    m_valid = 1'b1;
                end else if (wr) begin
                    m_ir     = data;
                    m_valid  = 1'b1;
                    consumed = 1'b1;
                end else begin
                    m_valid = 1'b0;
                end
            end
            if (wr && !consumed) begin
                if (mq.size() < DEPTH) mq.push_back(data);
                else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic step(input logic wr, input logic adv, input logic fl, input logic [15:0] data);
        @(negedge clk);
        C_IRWrite   = wr;
        C_IRAdvance = adv;
        C_Flush     = fl;
        D_MemData   = data;
        model_step(wr, adv, fl, data);
        exp_q.push_back(snapshot());
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        @(negedge clk);
        C_IRWrite   = 1'b0;
        C_IRAdvance = 1'b0;
        C_Flush     = 1'b0;
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) compare_outputs(exp_q.pop_front());
        end
    end

    initial begin : stim
        exp_t r;
        rst_n       = 1'b0;
        D_MemData   = '0;
        C_IRWrite   = 1'b0;
        C_IRAdvance = 1'b0;
        C_Flush     = 1'b0;
        m_ir        = '0;
        m_valid     = 1'b0;
        m_ovf       = 1'b0;
        #2;
        compare_outputs(snapshot());
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single push then advance
        step(1'b1, 1'b0, 1'b0, 16'h1234);
        step(1'b0, 1'b1, 1'b0, 16'h0000);
        after_edge();
        chk("d037_opcode", 32'(OPCODE), 32'h1);
        chk("d037_rt_bt",  32'(A_WriteRegRT_BT), 32'h2);
        chk("d037_swlw",   32'(A_RegSWLW), 32'h0);
        chk("d037_offset", 32'(A_Offset), 32'h2);
        chk("d037_read1",  32'(A_ReadReg1RT), 32'h3);
        chk("d037_func",   32'(FUNCFIELD), 32'h4);
        chk("d037_valid",  32'(IR_Valid), 32'h1);

        // Fill, overflow, drain in order
        step(1'b0, 1'b0, 1'b1, 16'h0000);
        for (int k = 1; k <= 5; k++) step(1'b1, 1'b0, 1'b0, 16'hA000 + 16'(k));
        after_edge();
        chk("d038_full", 32'(Q_Full), 32'h1);
        chk("d038_ovf",  32'(Q_Overflow), 32'h1);
        for (int k = 1; k <= 4; k++) begin
            step(1'b0, 1'b1, 1'b0, 16'h0000);
            after_edge();
            chk("d038_drain_op",   32'(OPCODE), 32'hA);
            chk("d038_drain_func", 32'(FUNCFIELD), 32'(k));
        end

        // Bypass into an empty queue
        step(1'b1, 1'b1, 1'b0, 16'h5F0E);
        after_edge();
        chk("d039_opcode", 32'(OPCODE), 32'h5);
        chk("d039_func",   32'(FUNCFIELD), 32'hE);
        chk("d039_count",  32'(Q_Count), 32'h0);

        // Push and pop together at full
        step(1'b0, 1'b0, 1'b1, 16'h0000);
        for (int k = 1; k <= 4; k++) step(1'b1, 1'b0, 1'b0, 16'hB000 + 16'(k));
        step(1'b1, 1'b1, 1'b0, 16'hB005);
        after_edge();
        chk("d040_count", 32'(Q_Count), 32'h4);
        chk("d040_ovf",   32'(Q_Overflow), 32'h0);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0, 16'h0000);
        after_edge();
        chk("d040_last", 32'(FUNCFIELD), 32'h5);

        // Flush dominates push and advance
        for (int k = 1; k <= 3; k++) step(1'b1, 1'b0, 1'b0, 16'hC000 + 16'(k));
        step(1'b1, 1'b1, 1'b1, 16'hC004);
        after_edge();
        chk("d041_count", 32'(Q_Count), 32'h0);
        chk("d041_valid", 32'(IR_Valid), 32'h0);
        chk("d041_func",  32'(FUNCFIELD), 32'h5);

        // Asynchronous reset between edges
        step(1'b1, 1'b0, 1'b0, 16'hD001);
        step(1'b1, 1'b1, 1'b0, 16'hD002);
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        mq.delete();
        m_ir    = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        compare_outputs(snapshot());
        idle();
        rst_n = 1'b1;

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 4,
                 $urandom_range(0, 19) == 0, 16'($urandom));
        end
        idle();

        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
        #3;
        if (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            chk("scoreboard_drain", 32'(exp_q.size() + 1), 32'h0);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
